iter_shifter: RTL and testbench

Multi-cycle, parametrised shifter for the datapath. It is the sequential successor to the fixed 2-bit jump-target shifter, generalised to any power-of-two width, a variable shift amount and four modes. Each cycle it applies one logarithmic stage, shifting by 2^k when bit k of the shift amount is set. It serves the multi-cycle ALU path for SLL/SRL/SRA/ROTL with a start/done handshake.

---
 rtl/iter_shifter_pkg.sv | 15 +
 rtl/iter_shifter_stage.sv | 35 +++
 rtl/iter_shifter.sv | 90 +++++++++
 tb/tb_iter_shifter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iter_shifter_pkg.sv
// rtl/iter_shifter_pkg.sv - shared mode constants and FSM state encodings for iter_shifter
package iter_shifter_pkg;

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shifter_stage.sv
// rtl/iter_shifter_stage.sv - combinational single logarithmic stage: shift data by 2^k per mode
import iter_shifter_pkg::*;

module shift_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int K_W     = $clog2(SHAMT_W)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] shifted
);

    // One extra bit so WIDTH itself is representable for the rotate back-shift.
    localparam int AMT_W = SHAMT_W + 1;
    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

    logic [AMT_W-1:0] amt;
    logic [AMT_W-1:0] rot_back;

    always_comb begin
        amt      = AMT_W'(1) << k;
        rot_back = WIDTH_A - amt;
        shifted  = data;
        case (mode)
            MODE_SLL:  shifted = data << amt;
            MODE_SRL:  shifted = data >> amt;
            MODE_SRA:  shifted = $signed(data) >>> amt;
            MODE_ROTL: shifted = (data << amt) | (data >> rot_back);
            default:   shifted = data;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter applying one log stage per cycle with start/done handshake
import iter_shifter_pkg::*;

module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int K_W = $clog2(SHAMT_W);
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stage_out;
    logic [WIDTH-1:0]   work_next;
    logic [SHAMT_W-1:0] shamt_reg;
    logic [1:0]         mode_reg;
    logic [K_W-1:0]     k;
    logic               accept;
    logic               last_stage;

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .K_W     (K_W)
    ) u_stage (
        .data    (work),
        .mode    (mode_reg),
        .k       (k),
        .shifted (stage_out)
    );

    assign work_next  = shamt_reg[k] ? stage_out : work;
    assign last_stage = (k == K_LAST);
    // A start is honoured whenever the block is not mid-operation, including the done cycle.
    assign accept     = start && (state != S_RUN);
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_stage) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work      <= '0;
            shamt_reg <= '0;
            mode_reg  <= '0;
            k         <= '0;
            result    <= '0;
        end else if (accept) begin
            work      <= operand;
            shamt_reg <= shamt;
            mode_reg  <= mode;
            k         <= '0;
        end else if (state == S_RUN) begin
            work <= work_next;
            k    <= k + 1'b1;
            if (last_stage) begin
                result <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter (32-bit and 8-bit instances)
module tb_iter_shifter;
    import iter_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        start8;
    logic [1:0]  mode8;
    logic [7:0]  operand8;
    logic [2:0]  shamt8;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    iter_shifter #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .start   (start8),
        .mode    (mode8),
        .operand (operand8),
        .shamt   (shamt8),
        .busy    (busy8),
        .done    (done8),
        .result  (result8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] op, input logic [4:0] sh);
        logic [31:0] r;
        r = op;
        case (m)
            MODE_SLL: r = op << sh;
            MODE_SRL: r = op >> sh;
            MODE_SRA: r = $signed(op) >>> sh;
            default: begin
                for (int i = 0; i < int'(sh); i++) r = {r[30:0], r[31]};
            end
        endcase
        return r;
    endfunction

    // Every done pulse retires the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("result", result, exp_q.pop_front());
        end
    end

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] m, input logic [31:0] op, input logic [4:0] sh);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; mode = m; operand = op; shamt = sh;
        exp_q.push_back(model(m, op, sh));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        chk("latency", lat, 5);
        chk("busy_cycles", bcnt, 5);
        @(posedge clk);
        #1 chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;
        reset = 1'b1; start = 1'b0; mode = '0; operand = '0; shamt = '0;
        start8 = 1'b0; mode8 = '0; operand8 = '0; shamt8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk) reset = 1'b0;

        run_op(MODE_SLL, 32'h0000_0001, 5'd31);
        run_op(MODE_SRA, 32'h8000_0000, 5'd4);
        run_op(MODE_SRL, 32'h8000_0000, 5'd4);
        run_op(MODE_ROTL, 32'h8000_0001, 5'd1);
        for (int m = 0; m < 4; m++) run_op(2'(m), 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 12; i++)
            run_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));

        // Back-to-back: ignored start while busy, accepted start in the done cycle.
        @(negedge clk);
        start = 1'b1; mode = MODE_SLL; operand = 32'h1; shamt = 5'd4;
        exp_q.push_back(32'h0000_0010);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; mode = MODE_ROTL; operand = 32'hFFFF_0000; shamt = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        chk("ignored_start_lat", lat, 3);
        start = 1'b1; mode = MODE_SRL; operand = 32'h0000_0100; shamt = 5'd8;
        exp_q.push_back(32'h0000_0001);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_latency", lat, 5);
        @(posedge clk);
        #1 chk("b2b_done_pulse", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; mode = MODE_SLL; operand = 32'hF; shamt = 5'd3;
        exp_q.push_back(32'h78);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_done", {31'd0, done}, 32'd0);
        chk("midrun_rst_result", result, 32'd0);
        exp_q.delete();
        #2 reset = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done === 1'b1) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_state", {30'd0, dut.state}, {30'd0, S_IDLE});

        // 8-bit instance: SRA 0x90 by 3.
        @(negedge clk);
        start8 = 1'b1; mode8 = MODE_SRA; operand8 = 8'h90; shamt8 = 3'd3;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("w8_latency", lat, 3);
        chk("w8_result", {24'd0, result8}, 32'h0000_00F2);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
